bicubic_line_buffer: RTL
========================

# bicubic_line_buffer

Row-window stage feeding the bicubic interpolator. It accepts a raster stream of 24-bit RGB pixels and stores the last rows in four internal single-port line SRAMs (`sram`, DEPTH = IMG_W, DATA_WIDTH = 24). For every accepted pixel it emits a 4-row vertical column (rows r-3..r, same column) with top-edge clamping. It sits between the input pixel stream and the bicubic kernel.

## Interface
- IMG_W, 960: pixels per row; also the depth of each line SRAM.
- IMG_H, 540: rows per frame.
- DATA_WIDTH, 24: pixel width.
- clk  in  1  clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input can be accepted this cycle.
- in_data  in  DATA_WIDTH  input pixel, raster order.
- out_valid  out  1  column window valid.
- out_ready  in  1  downstream accepts window.
- out_data  out  4*DATA_WIDTH  [4W-1:3W] = row r-3, [3W-1:2W] = row r-2, [2W-1:W] = row r-1, [W-1:0] = row r (current).
- out_eol  out  1  window is the last column of a row.
- out_eof  out  1  window is the last column of the last row.

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept. col wraps to 0 at IMG_W-1 and row increments. After col = IMG_W-1 and row = IMG_H-1, both wrap to 0 (next frame).
- Bank mapping: row j is stored in bank j mod 4 at address col.
- On accept at (row r, col c):
  - Bank r mod 4: cs_n = 0, wr_en = 1, data_in = in_data, addr = c.
  - For tap k = 1..3, source row s_k = max(r-k, 0).
    - If s_k = r (only when r = 0), the tap uses the bypassed current pixel.
    - Otherwise bank s_k mod 4 is read: cs_n = 0, wr_en = 0, addr = c. Several taps may share one bank read.
  - Unused banks: cs_n = 1.
  - No bank is both written and read in one cycle: for r ≥ 1 every s_k ≠ r mod 4. Check this with an assertion.
- When no pixel is accepted, all cs_n = 1 and SRAM outputs read as zero. The block therefore keeps a hold register.
- Pipeline register (loaded on accept): current pixel, tap bank selects, bypass flags, eol (c = IMG_W-1), eof (eol && r = IMG_H-1).
- out_data is taken from SRAM outputs in the cycle immediately after accept. In any later cycle it comes from the hold register.
- If out_valid && !out_ready, the hold register captures the current out_data at that edge. out_data stays stable until it is accepted.
- Top clamp:
  - r = 0: all four lanes = current pixel.
  - r = 1: lanes 3..1 = row 0.
  - r = 2: lanes 3,2 = row 0, lane 1 = row 1.
  - r ≥ 3: true rows.
- Reset:
  - col, row, out_valid, out_eol, out_eof, hold register, held flag, pipeline register all = 0; in_ready = 1.
  - SRAM contents are not cleared. They need no clearing, because row 0 is always written before it is read.
  - Reset mid-frame discards the pending window and restarts at (0,0).

## Timing
- Latency: a pixel accepted at edge t gives out_valid = 1 from edge t+1.
- Throughput: one pixel per cycle while out_ready = 1.
- out_valid clears at an edge where out_ready = 1 and no new accept occurs.
- Accept while out_valid && out_ready replaces the window back-to-back, with no bubble.
- out_data, out_eol and out_eof hold stable while out_valid && !out_ready.
- SRAM read data is used exactly one cycle after the cs_n = 0 read.
- Stall followed by release: the window comes from the hold register; the next accepted pixel comes from the SRAMs again.

## Test plan
- Reset then stream rows 0..3 of IMG_W=8, pixel = {row,col,0} with continuous out_ready.
  - Row 0: all lanes = {0,c}.
  - Row 3 col 5: out_data = {{0,5},{1,5},{2,5},{3,5}}, latency 1 cycle.
- Rows 4..7: row 6 col 2 window = {3,4,5,6} at col 2. Bank wrap reuses banks 0..2 correctly.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles mid-row 4. out_data stays constant, in_ready = 0, and no counter advances.
  - After release, windows resume with no loss or duplication.
- in_valid gaps (1-of-3 duty): no spurious out_valid, and all cs_n = 1 on idle cycles.
- Full frame IMG_W=8, IMG_H=5:
  - out_eol pulses on col 7 of every row; out_eof only at (4,7).
  - The next pixel is treated as row 0 (all lanes equal).
- Assert rst during row 2 col 3:
  - Next cycle: out_valid = 0, in_ready = 1.
  - The next pixel yields a row-0 window (all lanes = new pixel).

Source files
------------

// File: rtl/bicubic_line_buffer.sv
`timescale 1ns/1ps
// bicubic_line_buffer
// Row-window stage ahead of the bicubic kernel. Raster pixels are written into four
// line SRAMs (row j -> bank j mod 4, address = column). For every accepted pixel a
// 4-row vertical column (rows r-3..r) is emitted one cycle later, with top-edge clamping.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input pixel valid
//   in_ready   input accepted this cycle when high
//   in_data    input pixel, raster order
//   out_valid  column window valid
//   out_ready  downstream accepts window
//   out_data   {row r-3, row r-2, row r-1, row r}
//   out_eol    window is the last column of a row
//   out_eof    window is the last column of the last row
module bicubic_line_buffer #(
    parameter int unsigned IMG_W      = 960,
    parameter int unsigned IMG_H      = 540,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic                    out_eol,
    output logic                    out_eof
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 4) ? $clog2(IMG_H) : 2;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          accept;
    logic          last_col;
    logic          last_row;

    assign in_ready = !out_valid || out_ready;
    // Reset wins over a simultaneous handshake so no SRAM is touched in a reset cycle.
    assign accept   = in_valid && in_ready && !rst;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    // Bank control for the current pixel
    logic [3:0]      bank_wr;
    logic [3:0]      bank_rd;
    logic [3:0]      bank_cs_n;
    logic [2:0][1:0] tap_sel_d;
    logic [2:0]      tap_byp_d;

    always_comb begin
        bank_wr   = '0;
        bank_rd   = '0;
        tap_sel_d = '0;
        tap_byp_d = '0;
        for (int k = 1; k <= 3; k++) begin
            if (row_q == '0) begin
                // Row 0: every tap clamps onto the pixel being written right now.
                tap_byp_d[k-1] = 1'b1;
            end else begin
                if (row_q >= RW'(k)) begin
                    tap_sel_d[k-1] = row_q[1:0] - 2'(k);
                end else begin
                    tap_sel_d[k-1] = 2'd0;
                end
                bank_rd = bank_rd | (4'(accept) << tap_sel_d[k-1]);
            end
        end
        bank_wr[row_q[1:0]] = accept;
    end

    assign bank_cs_n = ~(bank_wr | bank_rd);

    // Line SRAMs: registered read, output reads zero when not selected for a read.
    logic [3:0][W-1:0] bank_q;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [W-1:0] mem [IMG_W];
        logic [W-1:0] q;

        always_ff @(posedge clk) begin
            if (!bank_cs_n[b] && bank_wr[b]) begin
                mem[col_q] <= in_data;
            end
            if (!bank_cs_n[b] && !bank_wr[b]) begin
                q <= mem[col_q];
            end else begin
                q <= '0;
            end
        end

        assign bank_q[b] = q;
    end

    // Pipeline and hold state
    logic [W-1:0]     cur_q;
    logic [2:0][1:0]  tap_sel_q;
    logic [2:0]       tap_byp_q;
    logic             out_valid_q;
    logic             eol_q;
    logic             eof_q;
    logic             held_q;
    logic [4*W-1:0]   hold_q;
    logic [4*W-1:0]   win;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            cur_q       <= '0;
            tap_sel_q   <= '0;
            tap_byp_q   <= '0;
            out_valid_q <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            held_q      <= 1'b0;
            hold_q      <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            cur_q       <= in_data;
            tap_sel_q   <= tap_sel_d;
            tap_byp_q   <= tap_byp_d;
            eol_q       <= last_col;
            eof_q       <= last_col && last_row;
            out_valid_q <= 1'b1;
            held_q      <= 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            // SRAM read data is only valid for one cycle; park the window while stalled.
            hold_q <= out_data;
            held_q <= 1'b1;
        end
    end

    always_comb begin
        win        = '0;
        win[W-1:0] = cur_q;
        for (int k = 1; k <= 3; k++) begin
            win[k*W +: W] = tap_byp_q[k-1] ? cur_q : bank_q[tap_sel_q[k-1]];
        end
    end

    assign out_data  = held_q ? hold_q : win;
    assign out_valid = out_valid_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

    // The bank being written is never one of the banks being read.
    always_ff @(posedge clk) begin
        if (accept && row_q != '0) begin
            assert ((bank_wr & bank_rd) == 4'b0);
        end
    end

endmodule
